// File: rtl/i2s_tdm_tx.sv
// ---------------------------------------------------------------------------
// i2s_tdm_tx -- I2S/TDM serial transmitter
//
// Parallel samples arrive on a valid/ready stream into a single holding
// register. At every slot start the held sample moves into a shift register
// and is shifted out MSB-first on i2s_sdata. Bits past the valid word width
// are zero-padded up to SLOT_WIDTH.
//
// i2s_ws is a one-bclk frame pulse coinciding with the last bit of the last
// slot, so the MSB of slot 0 follows one bclk later (I2S one-bit delay).
//
// Bit timing comes from bclk_fall, a one-clk strobe in the clk domain that
// marks each bclk falling edge. All serial outputs are registered and move
// only on the clk edge that samples the strobe.
//
// Optional build macro:
//   I2S_TX_UNDERFLOW_REPEAT_EN - on underflow, retransmit the last sample
//                                instead of zeros (underflow still pulses).
// ---------------------------------------------------------------------------
module i2s_tdm_tx #(
    parameter int SLOT_WIDTH = 32,
    parameter int MAX_SLOTS  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bclk_fall,
    input  logic [1:0]  valid_word_width,
    input  logic [3:0]  tdm_slots,
    input  logic [31:0] s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic        i2s_sdata,
    output logic        i2s_ws,
    output logic [2:0]  tx_slot,
    output logic        underflow
);

    localparam int BIT_BITS  = $clog2(SLOT_WIDTH);
    localparam int SLOT_BITS = (MAX_SLOTS > 1) ? $clog2(MAX_SLOTS) : 1;

    localparam logic [BIT_BITS-1:0]  BIT_LAST    = BIT_BITS'(SLOT_WIDTH - 1);
    localparam logic [BIT_BITS-1:0]  BIT_ONE     = BIT_BITS'(1);
    localparam logic [SLOT_BITS-1:0] SLOT_ONE    = SLOT_BITS'(1);
    localparam logic [3:0]           MAX_SLOTS_L = 4'(MAX_SLOTS);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Register code to number of valid bits; code 0 means disabled.
    function automatic logic [5:0] decode_width(input logic [1:0] code);
        logic [5:0] w;
        case (code)
            2'd1:    w = 6'd16;
            2'd2:    w = 6'd24;
            2'd3:    w = 6'd32;
            default: w = 6'd0;
        endcase
        return w;
    endfunction

    // Requested slot count limited to the supported range 2..MAX_SLOTS.
    function automatic logic [3:0] clamp_slots(input logic [3:0] n);
        logic [3:0] r;
        if (n < 4'd2) begin
            r = 4'd2;
        end else if (n > MAX_SLOTS_L) begin
            r = MAX_SLOTS_L;
        end else begin
            r = n;
        end
        return r;
    endfunction

    state_t                state;
    logic [BIT_BITS-1:0]   bit_cnt;
    logic [SLOT_BITS-1:0]  slot;
    logic [5:0]            cfg_width;
    logic [3:0]            cfg_slots;
    logic [31:0]           shift_reg;
    logic [31:0]           hold_data;
    logic                  hold_valid;
`ifdef I2S_TX_UNDERFLOW_REPEAT_EN
    logic [31:0]           last_sample;
`endif

    logic                  handshake;
    logic                  slot_start;
    logic                  boundary;
    logic [SLOT_BITS-1:0]  last_slot;
    logic [31:0]           fallback;
    logic [31:0]           word;
    logic                  emit_bit;
    logic [5:0]            next_width;
    logic [3:0]            next_slots;

    // Stream handshake, slot/frame position decode and the next serial bit.
    always_comb begin
        s_tready   = ~hold_valid & ~rst & ((state == RUN) | (valid_word_width != 2'd0));
        handshake  = s_tvalid & s_tready;
        last_slot  = SLOT_BITS'(cfg_slots - 4'd1);
        slot_start = (bit_cnt == '0);
        boundary   = (slot == last_slot) && (bit_cnt == BIT_LAST);
`ifdef I2S_TX_UNDERFLOW_REPEAT_EN
        fallback   = last_sample;
`else
        fallback   = 32'd0;
`endif
        if (slot_start) begin
            if (hold_valid) begin
                word = hold_data;
            end else begin
                word = fallback;
            end
        end else begin
            word = shift_reg;
        end
        if (6'(bit_cnt) < cfg_width) begin
            emit_bit = word[31];
        end else begin
            emit_bit = 1'b0;
        end
        next_width = decode_width(valid_word_width);
        next_slots = clamp_slots(tdm_slots);
    end

    // Transmit FSM: holding register, shifter, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            slot       <= '0;
            cfg_width  <= 6'd0;
            cfg_slots  <= 4'd0;
            shift_reg  <= 32'd0;
            hold_data  <= 32'd0;
            hold_valid <= 1'b0;
`ifdef I2S_TX_UNDERFLOW_REPEAT_EN
            last_sample <= 32'd0;
`endif
            i2s_sdata  <= 1'b0;
            i2s_ws     <= 1'b0;
            tx_slot    <= 3'd0;
            underflow  <= 1'b0;
        end else begin
            // underflow is a single-clk pulse
            underflow <= 1'b0;

            // A handshake needs an empty holding register, so it can never
            // collide with the slot-start transfer that empties it.
            if (handshake) begin
                hold_data  <= s_tdata;
                hold_valid <= 1'b1;
            end

            if (bclk_fall) begin
                case (state)
                    IDLE: begin
                        i2s_sdata <= 1'b0;
                        tx_slot   <= 3'd0;
                        if (valid_word_width != 2'd0) begin
                            // preamble bit: ws high, data low
                            cfg_width <= next_width;
                            cfg_slots <= next_slots;
                            i2s_ws    <= 1'b1;
                            bit_cnt   <= '0;
                            slot      <= '0;
                            state     <= RUN;
                        end else begin
                            i2s_ws <= 1'b0;
                        end
                    end

                    RUN: begin
                        i2s_sdata <= emit_bit;
                        tx_slot   <= 3'(slot);
                        shift_reg <= word << 1;

                        if (slot_start) begin
                            if (hold_valid) begin
                                hold_valid <= 1'b0;
`ifdef I2S_TX_UNDERFLOW_REPEAT_EN
                                last_sample <= hold_data;
`endif
                            end else begin
                                underflow <= 1'b1;
                            end
                        end

                        if (boundary) begin
                            // Frame boundary: pick up new configuration here only.
                            cfg_width <= next_width;
                            cfg_slots <= next_slots;
                            bit_cnt   <= '0;
                            slot      <= '0;
                            if (valid_word_width == 2'd0) begin
                                i2s_ws <= 1'b0;
                                state  <= IDLE;
                            end else begin
                                i2s_ws <= 1'b1;
                            end
                        end else begin
                            i2s_ws <= 1'b0;
                            if (bit_cnt == BIT_LAST) begin
                                bit_cnt <= '0;
                                slot    <= slot + SLOT_ONE;
                            end else begin
                                bit_cnt <= bit_cnt + BIT_ONE;
                            end
                        end
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// Directed testbench for i2s_tdm_tx: hand-computed serial bit streams per slot.
module tb_i2s_tdm_tx;

    logic        clk;
    logic        rst;
    logic        bclk_fall;
    logic [1:0]  valid_word_width;
    logic [3:0]  tdm_slots;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        i2s_sdata;
    logic        i2s_ws;
    logic [2:0]  tx_slot;
    logic        underflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] feed_q[$];

    logic        o_sd;
    logic        o_ws;
    logic [2:0]  o_slot;
    logic        o_uf;

    i2s_tdm_tx #(.SLOT_WIDTH(32), .MAX_SLOTS(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .bclk_fall        (bclk_fall),
        .valid_word_width (valid_word_width),
        .tdm_slots        (tdm_slots),
        .s_tdata          (s_tdata),
        .s_tvalid         (s_tvalid),
        .s_tready         (s_tready),
        .i2s_sdata        (i2s_sdata),
        .i2s_ws           (i2s_ws),
        .tx_slot          (tx_slot),
        .underflow        (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stream source: offers the head of feed_q, pops it once accepted.
    initial begin
        s_tvalid = 1'b0;
        s_tdata  = 32'd0;
        forever begin
            @(negedge clk);
            if (feed_q.size() > 0) begin
                s_tvalid = 1'b1;
                s_tdata  = feed_q[0];
            end else begin
                s_tvalid = 1'b0;
                s_tdata  = 32'd0;
            end
            #4;
            if (s_tvalid && s_tready) begin
                @(posedge clk);
                if (feed_q.size() > 0) void'(feed_q.pop_front());
            end
        end
    end

    // One bclk period: strobe for one clk, sample outputs just after that edge.
    task automatic tick();
        @(negedge clk);
        bclk_fall = 1'b1;
        @(posedge clk);
        #1;
        o_sd   = i2s_sdata;
        o_ws   = i2s_ws;
        o_slot = tx_slot;
        o_uf   = underflow;
        @(negedge clk);
        bclk_fall = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bclk_fall = 1'b0;
        feed_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic preamble(input string name);
        tick();
        n_checks++;
        if (o_ws !== 1'b1) begin
            n_fail++;
            $display("FAIL %s preamble ws got %0b exp 1", name, o_ws);
        end
        n_checks++;
        if (o_sd !== 1'b0) begin
            n_fail++;
            $display("FAIL %s preamble sdata got %0b exp 0", name, o_sd);
        end
    endtask

    // Checks one full slot; optionally queues push_val after bit push_at.
    task automatic run_slot(input logic [31:0] smp, input int width, input int slot,
                            input logic ws_last, input logic uf_exp,
                            input int push_at, input logic [31:0] push_val,
                            input string name);
        logic exp_bit;
        logic exp_ws;
        logic exp_uf;
        for (int b = 0; b < 32; b++) begin
            tick();
            exp_bit = (b < width) ? smp[31-b] : 1'b0;
            exp_ws  = (b == 31) ? ws_last : 1'b0;
            exp_uf  = (b == 0) ? uf_exp : 1'b0;
            n_checks++;
            if (o_sd !== exp_bit) begin
                n_fail++;
                $display("FAIL %s slot%0d bit%0d sdata got %0b exp %0b", name, slot, b, o_sd, exp_bit);
            end
            n_checks++;
            if (o_ws !== exp_ws) begin
                n_fail++;
                $display("FAIL %s slot%0d bit%0d ws got %0b exp %0b", name, slot, b, o_ws, exp_ws);
            end
            n_checks++;
            if (o_slot !== 3'(slot)) begin
                n_fail++;
                $display("FAIL %s slot%0d bit%0d tx_slot got %0d exp %0d", name, slot, b, o_slot, slot);
            end
            n_checks++;
            if (o_uf !== exp_uf) begin
                n_fail++;
                $display("FAIL %s slot%0d bit%0d underflow got %0b exp %0b", name, slot, b, o_uf, exp_uf);
            end
            if (b == push_at) feed_q.push_back(push_val);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        valid_word_width = 2'd1;
        tdm_slots = 4'd2;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bclk_fall = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({i2s_sdata, i2s_ws, tx_slot, underflow} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset outputs got sd=%0b ws=%0b slot=%0d uf=%0b exp all 0",
                     i2s_sdata, i2s_ws, tx_slot, underflow);
        end
        n_checks++;
        if (s_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset s_tready got %0b exp 0", s_tready);
        end
        @(negedge clk);
        bclk_fall = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (s_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release s_tready got %0b exp 1", s_tready);
        end
    endtask

    task automatic test_w16_two_slots();
        do_reset();
        valid_word_width = 2'd1;
        tdm_slots = 4'd2;
        feed_q.push_back(32'hA5A5_0000);
        feed_q.push_back(32'h3C3C_0000);
        repeat (4) @(posedge clk);
        preamble("w16");
        run_slot(32'hA5A5_0000, 16, 0, 1'b0, 1'b0, -1, 32'd0, "w16");
        run_slot(32'h3C3C_0000, 16, 1, 1'b1, 1'b0, -1, 32'd0, "w16");
    endtask

    task automatic test_w24_four_slots();
        do_reset();
        valid_word_width = 2'd2;
        tdm_slots = 4'd4;
        for (int i = 0; i < 4; i++) feed_q.push_back(32'hFFFF_FFFF);
        repeat (4) @(posedge clk);
        preamble("w24");
        for (int s = 0; s < 4; s++)
            run_slot(32'hFFFF_FFFF, 24, s, (s == 3), 1'b0, -1, 32'd0, "w24");
    endtask

    task automatic test_underflow();
        logic [31:0] exp2;
`ifdef I2S_TX_UNDERFLOW_REPEAT_EN
        exp2 = 32'h7FFE_0000;
`else
        exp2 = 32'd0;
`endif
        do_reset();
        valid_word_width = 2'd1;
        tdm_slots = 4'd4;
        feed_q.push_back(32'h8001_0000);
        feed_q.push_back(32'h7FFE_0000);
        repeat (4) @(posedge clk);
        preamble("uflow");
        run_slot(32'h8001_0000, 16, 0, 1'b0, 1'b0, -1, 32'd0, "uflow");
        run_slot(32'h7FFE_0000, 16, 1, 1'b0, 1'b0, -1, 32'd0, "uflow");
        run_slot(exp2,          16, 2, 1'b0, 1'b1, 0, 32'h5555_0000, "uflow");
        run_slot(32'h5555_0000, 16, 3, 1'b1, 1'b0, -1, 32'd0, "uflow");
    endtask

    task automatic test_width_change();
        do_reset();
        valid_word_width = 2'd1;
        tdm_slots = 4'd2;
        feed_q.push_back(32'h1234_5678);
        feed_q.push_back(32'h89AB_CDEF);
        feed_q.push_back(32'hDEAD_BEEF);
        feed_q.push_back(32'h0F0F_F0F1);
        repeat (4) @(posedge clk);
        preamble("wchg");
        run_slot(32'h1234_5678, 16, 0, 1'b0, 1'b0, -1, 32'd0, "wchg");
        valid_word_width = 2'd3;
        run_slot(32'h89AB_CDEF, 16, 1, 1'b1, 1'b0, -1, 32'd0, "wchg");
        run_slot(32'hDEAD_BEEF, 32, 0, 1'b0, 1'b0, -1, 32'd0, "wchg");
        run_slot(32'h0F0F_F0F1, 32, 1, 1'b1, 1'b0, -1, 32'd0, "wchg");
    endtask

    task automatic test_disable_to_idle();
        do_reset();
        valid_word_width = 2'd1;
        tdm_slots = 4'd2;
        feed_q.push_back(32'hFFFF_0000);
        feed_q.push_back(32'hFFFF_0000);
        repeat (4) @(posedge clk);
        preamble("dis");
        run_slot(32'hFFFF_0000, 16, 0, 1'b0, 1'b0, -1, 32'd0, "dis");
        valid_word_width = 2'd0;
        run_slot(32'hFFFF_0000, 16, 1, 1'b0, 1'b0, -1, 32'd0, "dis");
        for (int k = 0; k < 6; k++) begin
            tick();
            n_checks++;
            if ({o_sd, o_ws, o_uf} !== 3'b000) begin
                n_fail++;
                $display("FAIL idle tick%0d got sd=%0b ws=%0b uf=%0b exp 000", k, o_sd, o_ws, o_uf);
            end
        end
        n_checks++;
        if (s_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle s_tready got %0b exp 0", s_tready);
        end
    endtask

    task automatic test_reset_mid_slot();
        do_reset();
        valid_word_width = 2'd1;
        tdm_slots = 4'd2;
        feed_q.push_back(32'hFFFF_0000);
        feed_q.push_back(32'hFFFF_0000);
        repeat (4) @(posedge clk);
        preamble("rstmid");
        run_slot(32'hFFFF_0000, 16, 0, 1'b0, 1'b0, -1, 32'd0, "rstmid");
        repeat (5) tick();
        n_checks++;
        if ({o_sd, o_slot} !== {1'b1, 3'd1}) begin
            n_fail++;
            $display("FAIL rstmid before got sd=%0b slot=%0d exp sd=1 slot=1", o_sd, o_slot);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({i2s_sdata, i2s_ws, tx_slot, underflow, s_tready} !== 7'b0) begin
            n_fail++;
            $display("FAIL rstmid after got sd=%0b ws=%0b slot=%0d uf=%0b rdy=%0b exp all 0",
                     i2s_sdata, i2s_ws, tx_slot, underflow, s_tready);
        end
        @(negedge clk);
        rst = 1'b0;
        preamble("rstmid_restart");
    endtask

    initial begin
        rst = 1'b1;
        bclk_fall = 1'b0;
        valid_word_width = 2'd0;
        tdm_slots = 4'd2;
        test_reset();
        test_w16_two_slots();
        test_w24_four_slots();
        test_underflow();
        test_width_change();
        test_disable_to_idle();
        test_reset_mid_slot();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
